// File: rtl/kbd_autotype_arbiter.sv
// Arbitrates the keyboard matrix between live PS/2 keys and a FIFO of autotype entries.
// Each entry replays as an optional SHIFT lead, a key hold and a release gap. Outputs are active-high.
module kbd_autotype_arbiter #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned HOLD_CYCLES = 400000,
    parameter int unsigned GAP_CYCLES  = 400000,
    parameter int unsigned LEAD_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] live_KA,
    input  logic [6:0]  live_KD,
    input  logic        at_wr,
    input  logic [7:0]  at_data,
    input  logic        at_flush,
    output logic [11:0] KA,
    output logic [6:0]  KD,
    output logic        at_full,
    output logic        at_empty,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned HOLD_N = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int unsigned GAP_N  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned LEAD_N = (LEAD_CYCLES == 0) ? 1 : LEAD_CYCLES;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_N - 1);
    localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(LEAD_N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cur_row;
    logic [2:0]       cur_col;
    logic             cur_shift;

    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_n;
    logic [PW-1:0]    rd_ptr_n;

    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic [7:0]       head_c;
    logic [3:0]       head_row_c;
    logic [2:0]       head_col_c;
    logic             head_shift_c;
    logic             head_valid_c;
    logic [11:0]      hold_ka_c;
    logic [6:0]       hold_kd_c;

    // Live keys have priority: an entry only starts from IDLE with the live matrix fully released.
    assign pop_c  = (state == IDLE) && !at_empty && !at_flush
                    && (live_KA == '0) && (live_KD == '0);
    assign push_c = at_wr && !at_flush && (!at_full || pop_c);
    assign drop_c = at_wr && !at_flush && at_full && !pop_c;

    assign head_c       = mem[rd_ptr[AW-1:0]];
    assign head_row_c   = head_c[3:0];
    assign head_col_c   = head_c[6:4];
    assign head_shift_c = head_c[7];
    assign head_valid_c = (head_row_c <= 4'd11) && (head_col_c != 3'd7);

    assign hold_ka_c = (12'(1) << cur_row) | {11'b0, cur_shift};
    assign hold_kd_c = (7'(1) << cur_col) | {cur_shift, 6'b0};

    // Next FIFO pointers; a flush rewinds both to zero.
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        if (at_flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            if (push_c) wr_ptr_n = wr_ptr + PW'(1);
            if (pop_c)  rd_ptr_n = rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            at_full  <= 1'b0;
            at_empty <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            at_empty <= (wr_ptr_n == rd_ptr_n);
            at_full  <= (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0])
                        && (wr_ptr_n[AW] != rd_ptr_n[AW]);
            if (at_flush)    overflow <= 1'b0;
            else if (drop_c) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= at_data;
    end

    // Replay sequencer; KA/KD reflect the state held during the previous cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            cur_shift <= 1'b0;
            KA        <= '0;
            KD        <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    KA <= live_KA;
                    KD <= live_KD;
                    if (pop_c && head_valid_c) begin
                        cur_row   <= head_row_c;
                        cur_col   <= head_col_c;
                        cur_shift <= head_shift_c;
                        busy      <= 1'b1;
                        if (head_shift_c) begin
                            state <= LEAD;
                            cnt   <= LEAD_LOAD;
                        end else begin
                            state <= HOLD;
                            cnt   <= HOLD_LOAD;
                        end
                    end
                end
                LEAD: begin
                    KA <= 12'h001;
                    KD <= 7'h40;
                    if (at_flush) begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                    end else if (cnt == '0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    KA <= hold_ka_c;
                    KD <= hold_kd_c;
                    if (at_flush || (cnt == '0)) begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    KA <= '0;
                    KD <= '0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_autotype_arbiter.sv
// Bench for kbd_autotype_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_kbd_autotype_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned GAP   = 3;
    localparam int unsigned LEAD  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] live_KA = '0;
    logic [6:0]  live_KD = '0;
    logic        at_wr = 1'b0;
    logic [7:0]  at_data = '0;
    logic        at_flush = 1'b0;
    logic [11:0] KA;
    logic [6:0]  KD;
    logic        at_full;
    logic        at_empty;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    kbd_autotype_arbiter #(
        .DEPTH(DEPTH), .CNT_W(20), .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP), .LEAD_CYCLES(LEAD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .live_KA(live_KA), .live_KD(live_KD),
        .at_wr(at_wr), .at_data(at_data), .at_flush(at_flush),
        .KA(KA), .KD(KD), .at_full(at_full), .at_empty(at_empty),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: the pending replay is a list of per-cycle matrix values still to be shown.
    typedef struct packed {
        logic [11:0] ka;
        logic [6:0]  kd;
        logic        gap;
    } slot_t;

    slot_t       plan[$];
    logic [7:0]  q[$];
    logic [11:0] m_ka = '0;
    logic [6:0]  m_kd = '0;
    logic        m_ovf = 1'b0;

    function automatic int unsigned at_least_one(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic add_slots(input int unsigned n, input logic [11:0] ka,
                             input logic [6:0] kd, input logic gap);
        slot_t s;
        s.ka = ka; s.kd = kd; s.gap = gap;
        for (int i = 0; i < int'(n); i++) plan.push_back(s);
    endtask

    task automatic model_step();
        logic [7:0]  e;
        int unsigned row, col;
        logic [11:0] ka;
        logic [6:0]  kd;
        if (plan.size() == 0) begin
            m_ka = live_KA; m_kd = live_KD;
        end else begin
            m_ka = plan[0].ka; m_kd = plan[0].kd;
        end
        if (at_flush) begin
            q.delete();
            m_ovf = 1'b0;
            if (plan.size() != 0 && !plan[0].gap) begin
                plan.delete();
                add_slots(at_least_one(GAP), '0, '0, 1'b1);
            end else if (plan.size() != 0) begin
                void'(plan.pop_front());
            end
        end else begin
            if (plan.size() != 0) begin
                void'(plan.pop_front());
            end else if (q.size() != 0 && live_KA == 0 && live_KD == 0) begin
                e = q.pop_front();
                row = int'(e) % 16;
                col = (int'(e) / 16) % 8;
                if (row < 12 && col != 7) begin
                    ka = 12'(1 << row);
                    kd = 7'(1 << col);
                    if (e >= 8'h80) begin
                        add_slots(at_least_one(LEAD), 12'h001, 7'h40, 1'b0);
                        ka = ka + ((ka == 12'h001) ? 12'h000 : 12'h001);
                        kd = kd + ((kd == 7'h40) ? 7'h00 : 7'h40);
                    end
                    add_slots(at_least_one(HOLD), ka, kd, 1'b0);
                    add_slots(at_least_one(GAP), '0, '0, 1'b1);
                end
            end
            if (at_wr) begin
                if (q.size() < int'(DEPTH)) q.push_back(at_data);
                else m_ovf = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plan.delete(); q.delete();
            m_ka = '0; m_kd = '0; m_ovf = 1'b0;
        end else begin
            model_step();
        end
    end

    // Cycle compare against the model, 1 time unit after every rising edge.
    always begin
        @(posedge clk);
        #1;
        chk("cyc_KA", 32'(KA), 32'(m_ka));
        chk("cyc_KD", 32'(KD), 32'(m_kd));
        chk("cyc_full", 32'(at_full), 32'(q.size() == int'(DEPTH)));
        chk("cyc_empty", 32'(at_empty), 32'(q.size() == 0));
        chk("cyc_busy", 32'(busy), 32'(plan.size() != 0));
        chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic write(input logic [7:0] d);
        at_wr = 1'b1; at_data = d;
        step(1);
        at_wr = 1'b0;
    endtask

    int burst = 0;

    initial begin
        #1 reset_n = 1'b0;
        step(2);
        chk("rst_KA", 32'(KA), 32'h0);
        chk("rst_KD", 32'(KD), 32'h0);
        chk("rst_empty", 32'(at_empty), 32'h1);
        chk("rst_full", 32'(at_full), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        reset_n = 1'b1;
        step(1);

        // Plain key row5/col1
        write(8'h15);
        step(1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t1_hold_KA", 32'(KA), 32'h020);
            chk("t1_hold_KD", 32'(KD), 32'h02);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t1_gap_KA", 32'(KA), 32'h0);
            chk("t1_gap_KD", 32'(KD), 32'h0);
        end
        chk("t1_busy_end", 32'(busy), 32'h0);

        // Shifted key row3/col0
        write(8'h83);
        step(1);
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("t2_lead_KA", 32'(KA), 32'h001);
            chk("t2_lead_KD", 32'(KD), 32'h40);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t2_hold_KA", 32'(KA), 32'h009);
            chk("t2_hold_KD", 32'(KD), 32'h41);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t2_gap_KA", 32'(KA), 32'h0);
        end
        chk("t2_busy_end", 32'(busy), 32'h0);

        // Live keys block injection and are masked once it runs
        live_KA = 12'h004; live_KD = 7'h10;
        write(8'h15);
        step(3);
        chk("t3_live_KA", 32'(KA), 32'h004);
        chk("t3_live_KD", 32'(KD), 32'h10);
        chk("t3_idle_busy", 32'(busy), 32'h0);
        live_KA = '0; live_KD = '0;
        step(2);
        chk("t3_inject_KA", 32'(KA), 32'h020);
        live_KA = 12'hfff; live_KD = 7'h7f;
        step(1);
        chk("t3_masked_KA", 32'(KA), 32'h020);
        chk("t3_masked_KD", 32'(KD), 32'h02);
        step(8);
        chk("t3_follow_KA", 32'(KA), 32'hfff);
        live_KA = '0; live_KD = '0;
        step(2);

        // Fill past capacity while live is held
        live_KA = 12'h001;
        write(8'h01); write(8'h12); write(8'h23); write(8'h34);
        chk("t4_full", 32'(at_full), 32'h1);
        chk("t4_no_ovf_yet", 32'(overflow), 32'h0);
        write(8'h45);
        chk("t4_overflow", 32'(overflow), 32'h1);
        live_KA = '0;
        step(2);
        chk("t4_first_KA", 32'(KA), 32'h002);
        step(40);
        chk("t4_empty_end", 32'(at_empty), 32'h1);
        chk("t4_busy_end", 32'(busy), 32'h0);
        chk("t4_ovf_sticky", 32'(overflow), 32'h1);

        // Invalid entries are dropped silently
        write(8'h0c); write(8'h70); write(8'h00);
        step(1);
        chk("t5_no_output_KA", 32'(KA), 32'h0);
        chk("t5_busy", 32'(busy), 32'h1);
        step(1);
        chk("t5_key_KA", 32'(KA), 32'h001);
        chk("t5_key_KD", 32'(KD), 32'h01);
        step(10);

        // Flush in the second HOLD cycle
        live_KD = 7'h01;
        write(8'h15); write(8'h26); write(8'h37);
        live_KD = '0;
        step(2);
        at_flush = 1'b1;
        step(1);
        at_flush = 1'b0;
        chk("t6_empty", 32'(at_empty), 32'h1);
        chk("t6_ovf_clear", 32'(overflow), 32'h0);
        step(1);
        chk("t6_gap_KA", 32'(KA), 32'h0);
        step(2);
        chk("t6_gap3_KD", 32'(KD), 32'h0);
        step(1);
        chk("t6_busy_end", 32'(busy), 32'h0);
        step(10);
        chk("t6_no_more_KA", 32'(KA), 32'h0);

        // Asynchronous reset mid-HOLD
        write(8'h15);
        step(2);
        chk("t7_pre_KA", 32'(KA), 32'h020);
        reset_n = 1'b0;
        #1;
        chk("t7_async_KA", 32'(KA), 32'h0);
        chk("t7_async_KD", 32'(KD), 32'h0);
        chk("t7_async_busy", 32'(busy), 32'h0);
        step(1);
        reset_n = 1'b1;
        step(2);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (burst > 0) begin
                burst--;
            end else begin
                live_KA = '0; live_KD = '0;
                if ($urandom_range(99) < 3) begin
                    burst = int'($urandom_range(20, 1));
                    live_KA = 12'($urandom());
                    live_KD = 7'($urandom());
                end
            end
            at_wr    = ($urandom_range(99) < 25);
            at_data  = 8'($urandom());
            at_flush = ($urandom_range(199) == 0);
            reset_n  = ($urandom_range(999) != 0);
            step(1);
        end
        reset_n = 1'b1;
        at_wr = 1'b0; at_flush = 1'b0; live_KA = '0; live_KD = '0;
        step(80);
        chk("end_empty", 32'(at_empty), 32'h1);
        chk("end_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
